// File: rtl/channel_note_sequencer.sv
// Per-channel note sequencer: latches a song base offset, walks the note ROM from it and
// drives pitch/gate for each note's duration in beat ticks, ending on a marker or looping.
module channel_note_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int PITCH_W   = 8,
    parameter int DUR_W     = 8,
    parameter int ROM_LAT   = 1,
    parameter int MAX_NOTES = 4096,
    parameter int LOOP      = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     tick,
    input  logic [ADDR_W-1:0]        songpos,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [PITCH_W+DUR_W-1:0] rom_data,
    output logic [PITCH_W-1:0]       pitch,
    output logic                     gate,
    output logic                     note_strobe,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int IDX_W = $clog2(MAX_NOTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_DECODE, S_PLAY, S_DONE
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [IDX_W-1:0]    index_reg;
    logic [DUR_W-1:0]    dur_cnt_reg;
    logic [1:0]          wait_cnt_reg;
    logic [ADDR_W-1:0]   rom_addr_reg;
    logic [PITCH_W-1:0]  pitch_reg;
    logic                gate_reg;
    logic                note_strobe_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                overflow_reg;

    logic [PITCH_W-1:0]  rom_pitch;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_pitch = rom_data[PITCH_W+DUR_W-1:DUR_W];
    assign rom_dur   = rom_data[DUR_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            base_reg        <= '0;
            index_reg       <= '0;
            dur_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            rom_addr_reg    <= '0;
            pitch_reg       <= '0;
            gate_reg        <= 1'b0;
            note_strobe_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            note_strobe_reg <= 1'b0;
            // stop has priority over a coincident start
            if (stop) begin
                state_reg    <= S_IDLE;
                rom_addr_reg <= '0;
                pitch_reg    <= '0;
                gate_reg     <= 1'b0;
                busy_reg     <= 1'b0;
                done_reg     <= 1'b0;
            end else if (start) begin
                state_reg    <= S_LOAD;
                pitch_reg    <= '0;
                gate_reg     <= 1'b0;
                overflow_reg <= 1'b0;
                busy_reg     <= 1'b1;
                done_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: ;
                    S_LOAD: begin
                        base_reg  <= songpos;
                        index_reg <= '0;
                        state_reg <= S_FETCH;
                    end
                    S_FETCH: begin
                        rom_addr_reg <= base_reg + ADDR_W'(index_reg);
                        wait_cnt_reg <= '0;
                        state_reg    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt_reg == 2'(ROM_LAT - 1)) begin
                            state_reg <= S_DECODE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 2'd1;
                        end
                    end
                    S_DECODE: begin
                        if (index_reg == IDX_W'(MAX_NOTES)) begin
                            overflow_reg <= 1'b1;
                            pitch_reg    <= '0;
                            gate_reg     <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= S_DONE;
                        end else if (rom_dur == '0) begin
                            if (LOOP != 0) begin
                                index_reg <= '0;
                                state_reg <= S_FETCH;
                            end else begin
                                pitch_reg <= '0;
                                gate_reg  <= 1'b0;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= S_DONE;
                            end
                        end else if (rom_pitch == '0) begin
                            pitch_reg   <= '0;
                            gate_reg    <= 1'b0;
                            dur_cnt_reg <= rom_dur;
                            state_reg   <= S_PLAY;
                        end else begin
                            pitch_reg       <= rom_pitch;
                            gate_reg        <= 1'b1;
                            note_strobe_reg <= 1'b1;
                            dur_cnt_reg     <= rom_dur;
                            state_reg       <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        // pitch/gate are left alone here so consecutive notes stay legato
                        if (tick && !pause) begin
                            if (dur_cnt_reg == DUR_W'(1)) begin
                                index_reg <= index_reg + IDX_W'(1);
                                state_reg <= S_FETCH;
                            end else begin
                                dur_cnt_reg <= dur_cnt_reg - DUR_W'(1);
                            end
                        end
                    end
                    S_DONE: ;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign rom_addr    = rom_addr_reg;
    assign pitch       = pitch_reg;
    assign gate        = gate_reg;
    assign note_strobe = note_strobe_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_channel_note_sequencer.sv
// Scoreboard bench: three sequencer instances (plain, looping, small note guard) sharing one note ROM.
module tb_channel_note_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  start_v = '0;
    logic [2:0]  stop_v = '0;
    logic        pause = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] songpos = '0;

    logic [15:0] rom_addr_w [3];
    logic [15:0] rom_data_w [3];
    logic [7:0]  pitch_w [3];
    logic [2:0]  gate_w, strobe_w, busy_w, done_w, ovf_w;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [7:0] pitch;
        int         cyc;
    } exp_t;
    exp_t exp_q [$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int sel = 0;
    int start_cyc = 0;
    logic prev_strobe = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Registered-read note ROM, one cycle latency per instance
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) rom_data_w[i] <= mem[rom_addr_w[i]];
    end

    channel_note_sequencer #(.LOOP(0), .MAX_NOTES(4096)) dut_a (
        .clock(clock), .reset(reset), .start(start_v[0]), .stop(stop_v[0]), .pause(pause),
        .tick(tick), .songpos(songpos), .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0]),
        .pitch(pitch_w[0]), .gate(gate_w[0]), .note_strobe(strobe_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .overflow(ovf_w[0]));

    channel_note_sequencer #(.LOOP(1), .MAX_NOTES(4096)) dut_b (
        .clock(clock), .reset(reset), .start(start_v[1]), .stop(stop_v[1]), .pause(pause),
        .tick(tick), .songpos(songpos), .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1]),
        .pitch(pitch_w[1]), .gate(gate_w[1]), .note_strobe(strobe_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .overflow(ovf_w[1]));

    channel_note_sequencer #(.LOOP(0), .MAX_NOTES(2)) dut_c (
        .clock(clock), .reset(reset), .start(start_v[2]), .stop(stop_v[2]), .pause(pause),
        .tick(tick), .songpos(songpos), .rom_addr(rom_addr_w[2]), .rom_data(rom_data_w[2]),
        .pitch(pitch_w[2]), .gate(gate_w[2]), .note_strobe(strobe_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .overflow(ovf_w[2]));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    // Scoreboard consumer: every strobe of the selected instance must match the next expectation
    always @(negedge clock) begin
        if (!reset) begin
            if (strobe_w[sel] && prev_strobe) check_value("strobe_width", 32'd2, 32'd1);
            if (done_w[sel] && busy_w[sel]) check_value("done_and_busy", 32'd1, 32'd0);
            if (strobe_w[sel] && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    check_value("unexpected_strobe", {24'd0, pitch_w[sel]}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_value("strobe_pitch", {24'd0, pitch_w[sel]}, {24'd0, e.pitch});
                    check_value("strobe_gate", {31'd0, gate_w[sel]}, 32'd1);
                    if (e.cyc >= 0) check_value("strobe_cycle", cyc, e.cyc);
                end
            end
        end
        prev_strobe = strobe_w[sel];
    end

    task automatic push_exp(input logic [7:0] p, input int c);
        exp_t e;
        e.pitch = p;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int which, input logic [7:0] first_pitch, input bit timed);
        @(posedge clock); #1;
        start_cyc = cyc;
        if (timed) push_exp(first_pitch, start_cyc + 5);
        start_v[which] = 1'b1;
        @(posedge clock); #1;
        start_v[which] = 1'b0;
    endtask

    task automatic pulse_stop(input int which);
        @(posedge clock); #1;
        stop_v[which] = 1'b1;
        @(posedge clock); #1;
        stop_v[which] = 1'b0;
    endtask

    task automatic tick_pulse();
        @(posedge clock); #1;
        tick = 1'b1;
        @(posedge clock); #1;
        tick = 1'b0;
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_value("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[526]   = {8'h3C, 8'd2}; mem[527] = 16'h0000;
        mem[100]   = {8'h00, 8'd3}; mem[101] = {8'h40, 8'd1}; mem[102] = 16'h0000;
        mem[200]   = {8'h55, 8'd4}; mem[201] = 16'h0000;
        mem[300]   = {8'h60, 8'd1}; mem[301] = {8'h62, 8'd1}; mem[302] = 16'h0000;
        mem[16'hFFFF] = {8'h70, 8'd1}; mem[0] = {8'h71, 8'd1}; mem[1] = {8'h72, 8'd1};
        mem[400]   = {8'h66, 8'd5}; mem[401] = 16'h0000;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_value("rst_rom_addr", {16'd0, rom_addr_w[0]}, 32'd0);
        check_value("rst_pitch", {24'd0, pitch_w[0]}, 32'd0);
        check_value("rst_flags", {27'd0, gate_w[0], strobe_w[0], busy_w[0], done_w[0], ovf_w[0]}, 32'd0);

        // 1: single note then end marker
        sel = 0; songpos = 16'd526;
        pulse_start(0, 8'h3C, 1'b1);
        wait_drain(20);
        check_value("t1_busy", {31'd0, busy_w[0]}, 32'd1);
        check_value("t1_rom_addr", {16'd0, rom_addr_w[0]}, 32'd526);
        tick_pulse();
        check_value("t1_gate_after_tick1", {31'd0, gate_w[0]}, 32'd1);
        check_value("t1_pitch_after_tick1", {24'd0, pitch_w[0]}, 32'h3C);
        tick_pulse();
        check_value("t1_done", {31'd0, done_w[0]}, 32'd1);
        check_value("t1_gate_end", {31'd0, gate_w[0]}, 32'd0);
        check_value("t1_pitch_end", {24'd0, pitch_w[0]}, 32'd0);
        check_value("t1_busy_end", {31'd0, busy_w[0]}, 32'd0);

        // 2: rest for 3 ticks, then a note
        songpos = 16'd100;
        pulse_start(0, 8'h00, 1'b0);
        repeat (8) @(negedge clock);
        check_value("t2_rest_gate", {31'd0, gate_w[0]}, 32'd0);
        check_value("t2_rest_busy", {31'd0, busy_w[0]}, 32'd1);
        tick_pulse();
        tick_pulse();
        check_value("t2_rest_gate_t2", {31'd0, gate_w[0]}, 32'd0);
        push_exp(8'h40, -1);
        tick_pulse();
        wait_drain(20);
        check_value("t2_pitch", {24'd0, pitch_w[0]}, 32'h40);
        tick_pulse();
        check_value("t2_done", {31'd0, done_w[0]}, 32'd1);

        // 3: pause freezes the countdown of a 4-tick note
        songpos = 16'd200;
        pulse_start(0, 8'h55, 1'b1);
        wait_drain(20);
        tick_pulse();
        tick_pulse();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) tick_pulse();
        pause = 1'b0;
        check_value("t3_gate_after_pause", {31'd0, gate_w[0]}, 32'd1);
        check_value("t3_done_after_pause", {31'd0, done_w[0]}, 32'd0);
        tick_pulse();
        check_value("t3_gate_tick3", {31'd0, gate_w[0]}, 32'd1);
        tick_pulse();
        check_value("t3_done", {31'd0, done_w[0]}, 32'd1);

        // 4: looping song restarts from its base
        sel = 1; songpos = 16'd300;
        pulse_start(1, 8'h60, 1'b1);
        wait_drain(20);
        push_exp(8'h62, -1);
        tick_pulse();
        wait_drain(20);
        push_exp(8'h60, -1);
        tick_pulse();
        wait_drain(20);
        check_value("t4_rom_addr_base", {16'd0, rom_addr_w[1]}, 32'd300);
        check_value("t4_no_done", {31'd0, done_w[1]}, 32'd0);
        push_exp(8'h62, -1);
        tick_pulse();
        wait_drain(20);
        pulse_stop(1);
        @(negedge clock);
        check_value("t4_stopped_busy", {31'd0, busy_w[1]}, 32'd0);

        // 5: address wrap and note-count guard
        sel = 2; songpos = 16'hFFFF;
        pulse_start(2, 8'h70, 1'b1);
        wait_drain(20);
        check_value("t5_rom_addr_ffff", {16'd0, rom_addr_w[2]}, 32'hFFFF);
        push_exp(8'h71, -1);
        tick_pulse();
        wait_drain(20);
        check_value("t5_rom_addr_wrap", {16'd0, rom_addr_w[2]}, 32'h0000);
        tick_pulse();
        check_value("t5_overflow", {31'd0, ovf_w[2]}, 32'd1);
        check_value("t5_done", {31'd0, done_w[2]}, 32'd1);
        check_value("t5_gate", {31'd0, gate_w[2]}, 32'd0);
        pulse_start(2, 8'h70, 1'b1);
        @(negedge clock);
        check_value("t5_overflow_cleared", {31'd0, ovf_w[2]}, 32'd0);
        wait_drain(20);
        pulse_stop(2);

        // 6: stop+start together mid-note, then reset mid-WAIT
        sel = 0; songpos = 16'd400;
        pulse_start(0, 8'h66, 1'b1);
        wait_drain(20);
        check_value("t6_gate_playing", {31'd0, gate_w[0]}, 32'd1);
        @(posedge clock); #1;
        start_v[0] = 1'b1; stop_v[0] = 1'b1;
        @(posedge clock); #1;
        start_v[0] = 1'b0; stop_v[0] = 1'b0;
        @(negedge clock);
        check_value("t6_stop_busy", {31'd0, busy_w[0]}, 32'd0);
        check_value("t6_stop_gate", {31'd0, gate_w[0]}, 32'd0);
        check_value("t6_stop_pitch", {24'd0, pitch_w[0]}, 32'd0);
        repeat (4) @(negedge clock);
        check_value("t6_stays_idle", {31'd0, busy_w[0]}, 32'd0);
        pulse_start(0, 8'h00, 1'b0);
        @(posedge clock);
        @(posedge clock); #1;
        check_value("t6_wait_busy", {31'd0, busy_w[0]}, 32'd1);
        check_value("t6_wait_rom_addr", {16'd0, rom_addr_w[0]}, 32'd400);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_value("t6_rst_rom_addr", {16'd0, rom_addr_w[0]}, 32'd0);
        check_value("t6_rst_flags", {27'd0, gate_w[0], strobe_w[0], busy_w[0], done_w[0], ovf_w[0]}, 32'd0);
        repeat (10) @(negedge clock);
        check_value("t6_idle_after_rst", {31'd0, busy_w[0]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
